// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath: drives all datapath enables
// and mux selects per state and counts retired instructions.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCSource,
    output logic             IorD,
    output logic             IRWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        HALT     = 4'd10
    } state_t;

    // fetch_wr / branch_wr are the Moore halves of the input-qualified PC/IR loads
    typedef struct packed {
        logic       pc_source;
        logic       ior_d;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       halted;
        logic       fetch_wr;
        logic       branch_wr;
    } ctrl_t;

    state_t             state_r;
    state_t             state_next_s;
    ctrl_t              ctrl_r;
    logic               started_r;
    logic               retire_s;
    logic [CNT_W-1:0]   instr_count_r;

    function automatic ctrl_t decode_ctrl(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.fetch_wr  = 1'b1;
            end
            DECODE: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b10;
            end
            EXEC_R: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b00;
                c.alu_op    = 2'b10;
            end
            EXEC_I: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b10;
            end
            MEM_ADDR: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            MEM_RD: begin
                c.ior_d    = 1'b1;
                c.mem_read = 1'b1;
            end
            MEM_WR: begin
                c.ior_d     = 1'b1;
                c.mem_write = 1'b1;
            end
            WB_ALU: begin
                c.reg_write = 1'b1;
            end
            WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b00;
                c.alu_op    = 2'b01;
                c.pc_source = 1'b1;
                c.branch_wr = 1'b1;
            end
            HALT: begin
                c.halted = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Next-state selection; an unknown encoding falls into HALT
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH: begin
                if (mem_ready) state_next_s = DECODE;
                else           state_next_s = FETCH;
            end
            DECODE: begin
                case (Opcode)
                    7'b0110011: state_next_s = EXEC_R;
                    7'b0010011: state_next_s = EXEC_I;
                    7'b0000011: state_next_s = MEM_ADDR;
                    7'b0100011: state_next_s = MEM_ADDR;
                    7'b1100011: state_next_s = BRANCH;
                    default:    state_next_s = HALT;
                endcase
            end
            EXEC_R:   state_next_s = WB_ALU;
            EXEC_I:   state_next_s = WB_ALU;
            MEM_ADDR: begin
                if (Opcode == 7'b0100011) state_next_s = MEM_WR;
                else                      state_next_s = MEM_RD;
            end
            MEM_RD: begin
                if (mem_ready) state_next_s = WB_MEM;
                else           state_next_s = MEM_RD;
            end
            MEM_WR: begin
                if (mem_ready) state_next_s = FETCH;
                else           state_next_s = MEM_WR;
            end
            WB_ALU:  state_next_s = FETCH;
            WB_MEM:  state_next_s = FETCH;
            BRANCH:  state_next_s = FETCH;
            HALT:    state_next_s = HALT;
            default: state_next_s = HALT;
        endcase
    end

    // An instruction retires on the edge that leaves its final state
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            WB_ALU:  retire_s = 1'b1;
            WB_MEM:  retire_s = 1'b1;
            BRANCH:  retire_s = 1'b1;
            MEM_WR:  retire_s = mem_ready;
            default: retire_s = 1'b0;
        endcase
    end

    // State, registered Moore outputs and retire counter; the first edge after
    // reset only arms the FETCH outputs so every strobe is 0 while reset is held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= FETCH;
            ctrl_r        <= '0;
            started_r     <= 1'b0;
            instr_count_r <= '0;
        end else if (!started_r) begin
            started_r     <= 1'b1;
            state_r       <= FETCH;
            ctrl_r        <= decode_ctrl(FETCH);
            instr_count_r <= instr_count_r;
        end else begin
            started_r <= 1'b1;
            state_r   <= state_next_s;
            ctrl_r    <= decode_ctrl(state_next_s);
            if (retire_s) instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            else          instr_count_r <= instr_count_r;
        end
    end

    assign PCWrite     = (ctrl_r.fetch_wr & mem_ready) | (ctrl_r.branch_wr & Zero);
    assign IRWrite     = ctrl_r.fetch_wr & mem_ready;
    assign PCSource    = ctrl_r.pc_source;
    assign IorD        = ctrl_r.ior_d;
    assign ALUSrcA     = ctrl_r.alu_src_a;
    assign ALUSrcB     = ctrl_r.alu_src_b;
    assign ALUOp       = ctrl_r.alu_op;
    assign MemRead     = ctrl_r.mem_read;
    assign MemWrite    = ctrl_r.mem_write;
    assign MemtoReg    = ctrl_r.mem_to_reg;
    assign RegWrite    = ctrl_r.reg_write;
    assign halted      = ctrl_r.halted;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output vectors and retire
// counts checked against hand-derived values, plus a 4-bit counter instance.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [6:0]  Opcode;
    logic        Zero;
    logic        mem_ready;

    logic        pcw_a, pcs_a, iord_a, irw_a, mr_a, mw_a, mtr_a, rw_a, h_a;
    logic [1:0]  sa_a, sb_a, op_a;
    logic [31:0] cnt_a;
    logic        pcw_b, pcs_b, iord_b, irw_b, mr_b, mw_b, mtr_b, rw_b, h_b;
    logic [1:0]  sa_b, sb_b, op_b;
    logic [3:0]  cnt_b;

    int total;
    int bad;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(pcw_a), .PCSource(pcs_a), .IorD(iord_a), .IRWrite(irw_a),
        .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ALUOp(op_a), .MemRead(mr_a), .MemWrite(mw_a),
        .MemtoReg(mtr_a), .RegWrite(rw_a), .halted(h_a), .instr_count(cnt_a)
    );

    multicycle_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(pcw_b), .PCSource(pcs_b), .IorD(iord_b), .IRWrite(irw_b),
        .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ALUOp(op_b), .MemRead(mr_b), .MemWrite(mw_b),
        .MemtoReg(mtr_b), .RegWrite(rw_b), .halted(h_b), .instr_count(cnt_b)
    );

    // {PCWrite,PCSource,IorD,IRWrite,ALUSrcA,ALUSrcB,ALUOp,MemRead,MemWrite,MemtoReg,RegWrite,halted}
    logic [14:0] obs_a, obs_b;
    assign obs_a = {pcw_a, pcs_a, iord_a, irw_a, sa_a, sb_a, op_a, mr_a, mw_a, mtr_a, rw_a, h_a};
    assign obs_b = {pcw_b, pcs_b, iord_b, irw_b, sa_b, sb_b, op_b, mr_b, mw_b, mtr_b, rw_b, h_b};

    localparam logic [14:0] F_RDY  = {1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 1'b1, 4'b0000};
    localparam logic [14:0] F_WAIT = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 4'b0000};
    localparam logic [14:0] DEC    = {4'b0000, 2'b10, 2'b10, 2'b00, 5'b00000};
    localparam logic [14:0] EXR    = {4'b0000, 2'b01, 2'b00, 2'b10, 5'b00000};
    localparam logic [14:0] EXI    = {4'b0000, 2'b01, 2'b10, 2'b10, 5'b00000};
    localparam logic [14:0] MADR   = {4'b0000, 2'b01, 2'b10, 2'b00, 5'b00000};
    localparam logic [14:0] MRD    = {4'b0010, 6'b000000, 1'b1, 4'b0000};
    localparam logic [14:0] MWR    = {4'b0010, 6'b000000, 1'b0, 1'b1, 3'b000};
    localparam logic [14:0] WBA    = {4'b0000, 6'b000000, 3'b000, 1'b1, 1'b0};
    localparam logic [14:0] WBM    = {4'b0000, 6'b000000, 2'b00, 1'b1, 1'b1, 1'b0};
    localparam logic [14:0] BR_T   = {1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 5'b00000};
    localparam logic [14:0] BR_N   = {1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 5'b00000};
    localparam logic [14:0] HLT    = {14'b0, 1'b1};
    localparam logic [14:0] NONE   = 15'b0;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BQ = 7'b1100011;
    localparam logic [6:0] OP_XX = 7'b1111111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge: apply inputs, settle, check both instances, advance one cycle
    task automatic step(input string tag, input logic mr, input logic z, input logic [6:0] op,
                        input logic [14:0] exp_ctrl, input logic [31:0] exp_cnt);
        mem_ready = mr;
        Zero      = z;
        Opcode    = op;
        #1;
        chk({tag, "_ctrl"}, {17'd0, obs_a}, {17'd0, exp_ctrl});
        chk({tag, "_ctrl4"}, {17'd0, obs_b}, {17'd0, exp_ctrl});
        chk({tag, "_cnt"}, cnt_a, exp_cnt);
        chk({tag, "_cnt4"}, {28'd0, cnt_b}, {28'd0, exp_cnt[3:0]});
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("pre_first_edge", {17'd0, obs_a}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        mem_ready = 1'b1;
        Zero      = 1'b0;
        Opcode    = 7'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {17'd0, obs_a}, 32'd0);
        chk("rst_cnt", cnt_a, 32'd0);
        chk("rst_halted", {31'd0, h_a}, 32'd0);
        release_reset();

        // R-type, 4 cycles
        step("r_fetch", 1'b1, 1'b0, OP_R, F_RDY, 32'd0);
        step("r_dec",   1'b1, 1'b0, OP_R, DEC,   32'd0);
        step("r_exec",  1'b1, 1'b0, OP_R, EXR,   32'd0);
        step("r_wb",    1'b1, 1'b0, OP_R, WBA,   32'd0);

        // Load with two wait cycles in FETCH and in MEM_RD: 9 cycles
        step("ld_fw0",  1'b0, 1'b0, OP_LD, F_WAIT, 32'd1);
        step("ld_fw1",  1'b0, 1'b0, OP_LD, F_WAIT, 32'd1);
        step("ld_f",    1'b1, 1'b0, OP_LD, F_RDY,  32'd1);
        step("ld_dec",  1'b1, 1'b0, OP_LD, DEC,    32'd1);
        step("ld_addr", 1'b1, 1'b0, OP_LD, MADR,   32'd1);
        step("ld_rw0",  1'b0, 1'b0, OP_LD, MRD,    32'd1);
        step("ld_rw1",  1'b0, 1'b0, OP_LD, MRD,    32'd1);
        step("ld_rd",   1'b1, 1'b0, OP_LD, MRD,    32'd1);
        step("ld_wb",   1'b1, 1'b0, OP_LD, WBM,    32'd1);

        // Store, taken BEQ, not-taken BEQ: 10 cycles
        step("st_f",    1'b1, 1'b0, OP_ST, F_RDY, 32'd2);
        step("st_dec",  1'b1, 1'b0, OP_ST, DEC,   32'd2);
        step("st_addr", 1'b1, 1'b0, OP_ST, MADR,  32'd2);
        step("st_wr",   1'b1, 1'b0, OP_ST, MWR,   32'd2);
        step("bt_f",    1'b1, 1'b1, OP_BQ, F_RDY, 32'd3);
        step("bt_dec",  1'b1, 1'b1, OP_BQ, DEC,   32'd3);
        step("bt_br",   1'b1, 1'b1, OP_BQ, BR_T,  32'd3);
        step("bn_f",    1'b1, 1'b0, OP_BQ, F_RDY, 32'd4);
        step("bn_dec",  1'b1, 1'b0, OP_BQ, DEC,   32'd4);
        step("bn_br",   1'b1, 1'b0, OP_BQ, BR_N,  32'd4);

        // Illegal opcode: absorbing HALT, no further fetches, count frozen
        step("hx_f",    1'b1, 1'b0, OP_XX, F_RDY, 32'd5);
        step("hx_dec",  1'b1, 1'b0, OP_XX, DEC,   32'd5);
        for (int i = 0; i < 20; i++) begin
            step("halt", i[0], i[1], OP_R, HLT, 32'd5);
        end

        // Reset mid-instruction, during a MEM_WR wait
        reset = 1'b0;
        #1;
        chk("rst2_ctrl", {17'd0, obs_a}, 32'd0);
        release_reset();
        step("m_f",     1'b1, 1'b0, OP_R,  F_RDY, 32'd0);
        step("m_dec",   1'b1, 1'b0, OP_R,  DEC,   32'd0);
        step("m_exec",  1'b1, 1'b0, OP_R,  EXR,   32'd0);
        step("m_wb",    1'b1, 1'b0, OP_R,  WBA,   32'd0);
        step("ms_f",    1'b1, 1'b0, OP_ST, F_RDY, 32'd1);
        step("ms_dec",  1'b1, 1'b0, OP_ST, DEC,   32'd1);
        step("ms_addr", 1'b1, 1'b0, OP_ST, MADR,  32'd1);
        step("ms_ww0",  1'b0, 1'b0, OP_ST, MWR,   32'd1);
        mem_ready = 1'b0;
        #1;
        chk("ms_ww1_memwrite", {31'd0, mw_a}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_memwrite", {31'd0, mw_a}, 32'd0);
        chk("abort_ctrl", {17'd0, obs_a}, 32'd0);
        chk("abort_cnt", cnt_a, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_hold_ctrl", {17'd0, obs_a}, 32'd0);
        release_reset();

        // 17 R-types: 4-bit counter wraps to 1
        for (int n = 0; n < 17; n++) begin
            step("w_f",    1'b1, 1'b0, OP_R, F_RDY, n);
            step("w_dec",  1'b1, 1'b0, OP_R, DEC,   n);
            step("w_exec", 1'b1, 1'b0, OP_R, EXR,   n);
            step("w_wb",   1'b1, 1'b0, OP_R, WBA,   n);
        end
        chk("wrap_cnt4", {28'd0, cnt_b}, 32'd1);

        // I-type
        step("i_f",    1'b1, 1'b0, OP_I, F_RDY, 32'd17);
        step("i_dec",  1'b1, 1'b0, OP_I, DEC,   32'd17);
        step("i_exec", 1'b1, 1'b0, OP_I, EXI,   32'd17);
        step("i_wb",   1'b1, 1'b0, OP_I, WBA,   32'd17);
        step("i_done", 1'b1, 1'b0, OP_R, F_RDY, 32'd18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle variant of the RV32I processor datapath. It replaces the single-cycle Controller with a per-instruction state machine that fetches, decodes, executes, accesses memory and writes back over several clocks. A single unified memory with a `mem_ready` handshake serves both instruction and data accesses. The block drives every datapath enable and mux select, feeds `ALUOp` to the existing ALUController, and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Opcode` in 7: instruction register bits [6:0]. Valid from DECODE onward.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC register load enable.
- `PCSource` out 1: PC input select. 0 = ALU result, 1 = ALUOut register.
- `IorD` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: load IR and OldPC.
- `ALUSrcA` out 2: ALU A select. 00 = PC, 01 = rs1, 10 = OldPC.
- `ALUSrcB` out 2: ALU B select. 00 = rs2, 01 = constant 4, 10 = immediate.
- `ALUOp` out 2: 00 = add, 01 = subtract, 10 = use funct fields.
- `MemRead`, `MemWrite` out 1 each: memory strobes.
- `MemtoReg` out 1: write-back select. 1 = MDR, 0 = ALUOut.
- `RegWrite` out 1: register file write enable.
- `halted` out 1: sticky flag set after an illegal opcode.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, HALT.
- Outputs are a Moore function of the state, except these, which are gated by inputs:
  - the `PCWrite`/`IRWrite` qualifiers on `mem_ready`;
  - the `PCWrite` qualifier on `Zero`.
- All outputs not listed for a state are 0.
- FETCH:
  - Drives `IorD`=0, `MemRead`=1, `ALUSrcA`=00, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=0.
  - `IRWrite` = `PCWrite` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0, then goes to DECODE.
- DECODE:
  - Drives `ALUSrcA`=10, `ALUSrcB`=10, `ALUOp`=00, so ALUOut holds the branch target.
  - Next state by `Opcode`:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEM_ADDR
    - 1100011 → BRANCH
    - any other value → HALT
- EXEC_R: drives `ALUSrcA`=01, `ALUSrcB`=00, `ALUOp`=10, then → WB_ALU.
- EXEC_I: drives `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=10, then → WB_ALU.
- MEM_ADDR: drives `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00. Goes to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: drives `IorD`=1, `MemRead`=1. Holds until `mem_ready`, then → WB_MEM.
- MEM_WR:
  - Drives `IorD`=1, `MemWrite`=1.
  - Holds until `mem_ready`, then → FETCH; the store retires on that edge.
- WB_ALU: drives `RegWrite`=1, `MemtoReg`=0, then → FETCH.
- WB_MEM: drives `RegWrite`=1, `MemtoReg`=1, then → FETCH.
- BRANCH (BEQ):
  - Drives `ALUSrcA`=01, `ALUSrcB`=00, `ALUOp`=01, `PCSource`=1, `PCWrite`=`Zero`.
  - Goes to FETCH and retires whether or not the branch is taken.
- HALT: all strobes are 0, `halted`=1. The state is absorbing until reset.
- `instr_count`:
  - Increments by 1 on each edge that leaves WB_ALU, WB_MEM or BRANCH, and on the edge that leaves MEM_WR with `mem_ready`=1.
  - Wraps modulo 2^CNT_W.
  - An illegal instruction does not count.

## Timing
- Reset (`reset`=0):
  - Asynchronous, takes effect immediately.
  - state = FETCH, `instr_count` = 0, `halted` = 0.
  - All strobes read 0 while reset is held, except the FETCH Moore outputs after release.
- First FETCH begins on the first rising edge after `reset` rises.
- Latency per instruction with `mem_ready` tied high:
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each wait cycle (`mem_ready`=0) in FETCH, MEM_RD or MEM_WR adds exactly 1 cycle.
- `MemRead`/`MemWrite` and `IorD` stay stable through the whole wait.
- `mem_ready` outside FETCH, MEM_RD and MEM_WR is ignored.
- Reset mid-instruction:
  - Aborts the instruction immediately. No partial write is asserted after reset assertion.
  - `instr_count` clears.

## Test plan
- R-type, `mem_ready`=1, `Opcode`=0110011:
  - States FETCH, DECODE, EXEC_R, WB_ALU in 4 cycles.
  - `RegWrite`=1 for exactly 1 cycle.
  - `instr_count` 0→1.
- Load, `mem_ready` low for 2 cycles in both FETCH and MEM_RD:
  - Instruction takes 9 cycles.
  - `MemRead` held for 3 cycles in each access.
  - `MemtoReg`=1 with `RegWrite`=1 in WB_MEM.
- Store then BEQ with `Zero`=1, then BEQ with `Zero`=0:
  - `MemWrite` pulses once.
  - First BEQ asserts `PCWrite`=1, `PCSource`=1; second BEQ has `PCWrite`=0.
  - `instr_count`=3 after 10 cycles.
- `Opcode`=1111111 in DECODE:
  - Enters HALT; `halted`=1.
  - No further `MemRead` for 20 cycles.
  - `instr_count` unchanged.
- Assert `reset` low during MEM_WR wait:
  - `MemWrite` drops in the same cycle without a clock edge.
  - `instr_count`=0.
  - After release, FETCH restarts.
- With CNT_W=4, retire 17 R-type instructions: `instr_count` wraps to 1.
